// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the reset sequencer: the sequencing state encoding
// and the synchronizer depth used on every asynchronous input.
package reset_sequencer_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    WAIT_LOCK  = 2'd0,
    SETTLE     = 2'd1,
    REL_PERIPH = 2'd2,
    RUN        = 2'd3
  } seq_state_t;

endpackage

// File: rtl/reset_sequencer_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level into the clk domain.
// Clears to 0 so a held-off input always reads as inactive after reset.
module sync_bit
  import reset_sequencer_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_ff[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release: waits for a stable PLL lock, frees peripherals, then
// the core, and drops back to full reset on lock loss or a debounced button.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int SETTLE_CYCLES   = 1024,
  parameter int STAGE_GAP       = 16,
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       btn_rst,
  output logic       rst_periph,
  output logic       rst_core,
  output logic       sys_ready,
  output logic [7:0] lock_loss_cnt
);

  localparam int              DB_W        = $clog2(DEBOUNCE_CYCLES);
  localparam logic [15:0]     SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0]     GAP_LAST    = 16'(STAGE_GAP - 1);
  localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            locked_s;
  logic            btn_s;
  logic            btn_db;
  logic [DB_W-1:0] db_cnt;
  seq_state_t      state;
  seq_state_t      state_next;
  logic [15:0]     cnt;
  logic [15:0]     cnt_next;
  logic            abort;
  logic            loss;

  sync_bit u_sync_lock (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  sync_bit u_sync_btn (
    .clk (clk),
    .rst (rst),
    .d   (btn_rst),
    .q   (btn_s)
  );

  // Button level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_db <= 1'b0;
      db_cnt <= '0;
    end else if (btn_s == btn_db) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      btn_db <= btn_s;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

  assign abort = ~locked_s | btn_db;

  always_comb begin
    state_next = state;
    cnt_next   = '0;
    loss       = 1'b0;
    case (state)
      WAIT_LOCK: begin
        if (!abort) state_next = SETTLE;
      end
      SETTLE: begin
        if (abort)                    state_next = WAIT_LOCK;
        else if (cnt == SETTLE_LAST)  state_next = REL_PERIPH;
        else                          cnt_next   = cnt + 16'd1;
      end
      REL_PERIPH: begin
        if (abort)                    state_next = WAIT_LOCK;
        else if (cnt == GAP_LAST)     state_next = RUN;
        else                          cnt_next   = cnt + 16'd1;
      end
      RUN: begin
        if (abort) begin
          state_next = WAIT_LOCK;
          loss       = ~locked_s;
        end
      end
      default: state_next = WAIT_LOCK;
    endcase
  end

  // Outputs are registered from the next state so resets assert on the same edge as WAIT_LOCK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= WAIT_LOCK;
      cnt           <= '0;
      rst_periph    <= 1'b1;
      rst_core      <= 1'b1;
      sys_ready     <= 1'b0;
      lock_loss_cnt <= '0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      rst_periph <= (state_next == WAIT_LOCK) || (state_next == SETTLE);
      rst_core   <= (state_next != RUN);
      sys_ready  <= (state_next == RUN);
      if (loss && (lock_loss_cnt != 8'hFF)) begin
        lock_loss_cnt <= lock_loss_cnt + 8'd1;
      end
    end
  end

endmodule
